div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter Nbits, default 5: operand MSB index; all data ports are Nbits+1 bits wide (6 bits at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled on rising edge of clk.
REQ-005 div_in_a  input  Nbits+1  dividend, unsigned; captured on the accepted start edge.
REQ-006 div_in_b  input  Nbits+1  divisor, unsigned; captured on the accepted start edge.
REQ-007 busy  output  1  high while a division is in progress (CALC state).
REQ-008 done  output  1  one-cycle pulse; quo_out, rem_out and dbz are valid in this cycle.
REQ-009 quo_out  output  Nbits+1  quotient, unsigned.
REQ-010 rem_out  output  Nbits+1  remainder, unsigned.
REQ-011 dbz  output  1  divide-by-zero flag for the last completed division.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; an accepted start captures div_in_a and div_in_b, clears the bit counter and enters CALC (nonzero divisor) or DONE (zero divisor).
REQ-014 start in CALC SHALL be ignored: no recapture and no effect on the running division.
REQ-015 Division SHALL be radix-2 restoring, one quotient bit per CALC cycle, MSB first.
  - partial remainder Nbits+2 bits wide
  - shift in the next dividend bit; trial-subtract the divisor; keep the result and set the quotient bit to 1 if it is non-negative, else restore.
REQ-016 CALC SHALL last exactly Nbits+1 cycles, after which the FSM enters DONE.
REQ-017 For an accepted start on edge k with a nonzero divisor, done SHALL be high in exactly the cycle after edge k+Nbits+1 (edge k+6 at default).
REQ-018 quo_out and rem_out SHALL update only on the edge that enters DONE, and SHALL hold until the next DONE entry or reset.
REQ-019 With a nonzero divisor, the results SHALL satisfy div_in_a = quo_out*div_in_b + rem_out, with rem_out < div_in_b.
REQ-020 With div_in_b = 0, the FSM SHALL enter DONE on edge k+1 and set quo_out = all ones, rem_out = div_in_a and dbz = 1.
REQ-021 dbz SHALL be 0 for every nonzero-divisor result and SHALL update with quo_out.
REQ-022 busy SHALL be 1 exactly when the state is CALC; done SHALL be 1 exactly when the state is DONE.
REQ-023 From DONE, the next edge SHALL go to CALC/DONE if start is high, else to IDLE; back-to-back operations therefore have no idle gap.
REQ-024 Dividend 0 SHALL yield quo_out = 0 and rem_out = 0 after the full CALC latency.
REQ-025 div_in_b > div_in_a SHALL yield quo_out = 0 and rem_out = div_in_a.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, force state IDLE, busy = 0, done = 0, quo_out = 0, rem_out = 0, dbz = 0 and clear internal registers.
REQ-027 Reset asserted mid-CALC SHALL abort the division; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first accepted start SHALL behave identically to one after power-up.

Verification
REQ-029 Basic divide: start with a=45, b=6 -> done exactly 6 cycles after the start edge; quo=7, rem=3, dbz=0; busy high for 6 cycles.
REQ-030 Small and large operands:
  - a=5, b=9 -> quo=0, rem=5
  - a=63, b=1 -> quo=63, rem=0
  - a=0, b=7 -> quo=0, rem=0, done still at 6 cycles
REQ-031 Divide by zero: a=12, b=0 -> done on the cycle after start; quo=63, rem=12, dbz=1, busy never high.
REQ-032 Start while busy: start a=45, b=6, then pulse start with a=9, b=3 at cycle 3 -> the second start is ignored; result is quo=7, rem=3.
REQ-033 Back-to-back: a=20, b=4 done; start held during the done cycle with a=63, b=8 -> busy on the next edge, then quo=7, rem=7; the first result reads quo=5, rem=0.
REQ-034 Reset mid-operation: rst_n low at CALC cycle 3 -> all outputs 0 immediately, no done; after release, a=17, b=5 -> quo=3, rem=2.

Source files
------------

// File: rtl/div_seq.sv
// Sequential radix-2 restoring unsigned divider: one quotient bit per cycle, result Nbits+1 cycles after start.
// A zero divisor finishes at once. start is accepted only in IDLE or DONE and is ignored while busy.
module div_seq #(
    parameter int Nbits = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Nbits:0] div_in_a,
    input  logic [Nbits:0] div_in_b,
    output logic           busy,
    output logic           done,
    output logic [Nbits:0] quo_out,
    output logic [Nbits:0] rem_out,
    output logic           dbz
);

    localparam int W  = Nbits + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    // The dividend register shifts left each step; quotient bits enter at its LSB.
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   prem_q, prem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quo_out_q, quo_out_d;
    logic [W-1:0]   rem_out_q, rem_out_d;
    logic           dbz_q, dbz_d;

    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           q_bit;
    logic [W-1:0]   prem_next;
    logic [W-1:0]   dvd_next;
    logic           unused_diff_msb;

    // The stored remainder is always below the divisor, so W bits suffice;
    // the shifted/trial values need the extra bit.
    always_comb begin
        shifted   = {prem_q, dvd_q[W-1]};
        diff      = shifted - {1'b0, dvs_q};
        q_bit     = (shifted >= {1'b0, dvs_q});
        prem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
        dvd_next  = {dvd_q[W-2:0], q_bit};
    end

    assign unused_diff_msb = diff[W];

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    dvd_d  = div_in_a;
                    dvs_d  = div_in_b;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (div_in_b == '0) begin
                        state_d   = S_DONE;
                        quo_out_d = '1;
                        rem_out_d = div_in_a;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d  = dvd_next;
                prem_d = prem_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d   = S_DONE;
                    quo_out_d = dvd_next;
                    rem_out_d = prem_next;
                    dbz_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy    = (state_q == S_CALC);
    assign done    = (state_q == S_DONE);
    assign quo_out = quo_out_q;
    assign rem_out = rem_out_q;
    assign dbz     = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed and random checks of div_seq against an arithmetic reference (a/b, a%b).
module tb_div_seq;

    localparam int NB = 5;
    localparam int W  = NB + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] div_in_a;
    logic [W-1:0] div_in_b;
    logic         busy;
    logic         done;
    logic [W-1:0] quo_out;
    logic [W-1:0] rem_out;
    logic         dbz;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;

    div_seq #(.Nbits(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .div_in_a (div_in_a),
        .div_in_b (div_in_b),
        .busy     (busy),
        .done     (done),
        .quo_out  (quo_out),
        .rem_out  (rem_out),
        .dbz      (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = W'(ai / bi);
            r = W'(ai % bi);
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                      input int inject_at);
        int lat, busy_cnt, exp_lat;
        model(a, b, exp_q, exp_r, exp_z);
        exp_lat  = (b == '0) ? 0 : W;
        start    = 1'b1;
        div_in_a = a;
        div_in_b = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        if (b != '0) chk({tag, "/busy_first"}, 32'(busy), 1);
        while (!done && lat < 3 * W) begin
            busy_cnt += int'(busy);
            if (lat == inject_at) begin
                start    = 1'b1;
                div_in_a = 9;
                div_in_b = 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "/done"},     32'(done),     1);
        chk({tag, "/latency"},  lat,           exp_lat);
        chk({tag, "/busy_cyc"}, busy_cnt,      exp_lat);
        chk({tag, "/busy_dn"},  32'(busy),     0);
        chk({tag, "/quo"},      32'(quo_out),  32'(exp_q));
        chk({tag, "/rem"},      32'(rem_out),  32'(exp_r));
        chk({tag, "/dbz"},      32'(dbz),      32'(exp_z));
    endtask

    task automatic idle_chk(input string tag);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "/done_pulse"}, 32'(done),    0);
        chk({tag, "/idle_busy"},  32'(busy),    0);
        chk({tag, "/hold_quo"},   32'(quo_out), 32'(exp_q));
        chk({tag, "/hold_rem"},   32'(rem_out), 32'(exp_r));
        chk({tag, "/hold_dbz"},   32'(dbz),     32'(exp_z));
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra, rb;
        rst_n    = 1'b1;
        start    = 1'b0;
        div_in_a = '0;
        div_in_b = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst/busy", 32'(busy),    0);
        chk("rst/done", 32'(done),    0);
        chk("rst/quo",  32'(quo_out), 0);
        chk("rst/rem",  32'(rem_out), 0);
        chk("rst/dbz",  32'(dbz),     0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/idle_done", 32'(done), 0);

        op(6'd45, 6'd6, "basic", -1);        idle_chk("basic");
        op(6'd5,  6'd9, "b_gt_a", -1);       idle_chk("b_gt_a");
        op(6'd63, 6'd1, "div_one", -1);      idle_chk("div_one");
        op(6'd0,  6'd7, "zero_dvd", -1);     idle_chk("zero_dvd");
        op(6'd12, 6'd0, "dbz", -1);          idle_chk("dbz");
        op(6'd45, 6'd6, "start_busy", 2);    idle_chk("start_busy");
        chk("start_busy/quo_val", 32'(quo_out), 7);

        op(6'd20, 6'd4, "b2b_first", -1);
        op(6'd63, 6'd8, "b2b_second", -1);
        idle_chk("b2b_second");

        // Abort a division in its third CALC cycle.
        start    = 1'b1;
        div_in_a = 6'd45;
        div_in_b = 6'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort/busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort/busy", 32'(busy),    0);
        chk("abort/done", 32'(done),    0);
        chk("abort/quo",  32'(quo_out), 0);
        chk("abort/rem",  32'(rem_out), 0);
        chk("abort/dbz",  32'(dbz),     0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort/no_done", seen, 0);
        op(6'd17, 6'd5, "after_rst", -1);    idle_chk("after_rst");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom_range(0, 63));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 63));
            op(ra, rb, $sformatf("rnd%0d", i), -1);
            if ($urandom_range(0, 1) == 0) idle_chk($sformatf("rnd%0d", i));
        end
        idle_chk("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
